delay_ram_scheduler: RTL and testbench
======================================

DELAY_RAM_SCHEDULER -- requirements
Module: delay_ram_scheduler

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, delay-RAM address width (depth 2^ADDR_W); DATA_W, default 11, sign-magnitude sample width; NTAPS, default 4, read taps per frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sample_tick  input  1  one-clk pulse starting a sample frame.
REQ-005 SHALL have port wr_sample  input  DATA_W  sample to store, captured on accepted sample_tick.
REQ-006 SHALL have port tap_en  input  NTAPS  per-tap enable, sampled on accepted sample_tick.
REQ-007 SHALL have port cfg_we  input  1  tap-offset config write strobe.
REQ-008 SHALL have port cfg_idx  input  $clog2(NTAPS)  tap index for cfg_we.
REQ-009 SHALL have port cfg_offset  input  ADDR_W  tap delay in samples.
REQ-010 SHALL have ports ram_we  output  1; ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_rdata  input  DATA_W (synchronous RAM, 1-cycle read latency).
REQ-011 SHALL have ports tap_data  output  NTAPS*DATA_W, tap k in bits [k*DATA_W +: DATA_W]; tap_valid  output  NTAPS.
REQ-012 SHALL have ports frame_done  output  1  one-clk pulse; busy  output  1; overrun  output  1  sticky.

Function
REQ-013 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE; busy=1 in every state except IDLE.
REQ-014 IDLE: sample_tick SHALL be accepted, latching wr_sample, tap_en, and copying pending offsets to active offsets; next state READ with k=0.
REQ-015 READ: slot k SHALL drive ram_addr = wptr - active_offset[k] (mod 2^ADDR_W), ram_we=0; after k=NTAPS-1 go to CAPTURE.
REQ-016 ram_rdata in the cycle after slot k SHALL be stored to tap k (0 if tap_en[k]=0).
REQ-017 CAPTURE: store last tap; go to WRITE.
REQ-018 WRITE: ram_we=1 for exactly one cycle, ram_addr=wptr, ram_wdata=latched sample; go to DONE.
REQ-019 DONE: wptr SHALL increment by 1 wrapping 2^ADDR_W-1 -> 0; tap_data/tap_valid (=latched tap_en) update together; frame_done=1; return to IDLE.
REQ-020 Fixed latency: frame_done SHALL assert NTAPS+3 cycles after the accepted sample_tick, independent of tap_en.
REQ-021 tap_data/tap_valid SHALL hold between frames (changed only in DONE).
REQ-022 Offset 0 SHALL return the word at wptr before this frame's write (oldest sample); no read-after-write bypass.
REQ-023 cfg_we SHALL update pending_offset[cfg_idx] at any time; it reaches active offsets only at the next accepted sample_tick; cfg_we coinciding with an accepted tick applies from the following frame.
REQ-024 sample_tick while busy SHALL be ignored and set overrun=1; overrun clears only on reset.
REQ-025 ram_we SHALL be 0 in all states other than WRITE; ram_addr holds its last value in IDLE.

Reset
REQ-026 On reset low: state IDLE, wptr=0, ram_we=0, ram_addr=0, ram_wdata=0, tap_data=0, tap_valid=0, frame_done=0, busy=0, overrun=0, pending and active offsets = package defaults 0x001, 0x080, 0x0C0, 0x100.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no RAM write and no frame_done.

Configuration
REQ-028 With TAP_MOD_EN defined: a 6-bit triangle LFO (0..63..0) SHALL step once per DONE, and its value SHALL be added to active offsets of taps 1..NTAPS-1 (tap 0 never modulated) when computing ram_addr; LFO resets to 0 rising.
REQ-029 Without TAP_MOD_EN: no LFO logic exists; addresses use active offsets unmodified.

Structure
REQ-030 Package delay_sched_pkg SHALL hold ADDR_W/DATA_W/NTAPS defaults, the state enum type, and the default offset table.
REQ-031 The LFO SHALL be sub-module tap_lfo, instantiated only under TAP_MOD_EN.

Verification
REQ-032 Reset then tick with wr_sample=0x155, tap_en=4'hF -> reads at 0x1FFF,0x1F80,0x1F40,0x1F00; write 0x155 at 0x0000; frame_done 7 cycles after tick; wptr=1.
REQ-033 8194 back-to-back frames writing frame index -> wrap at 0x1FFF->0x0000; tap offset 0x080 returns index-128 after wrap.
REQ-034 Tick during busy (cycle 3 of frame) -> ignored, overrun=1 sticky, frame timing unchanged.
REQ-035 cfg_we idx=2 offset=0x010 on tick cycle -> that frame still uses 0x0C0, next frame uses 0x010.
REQ-036 tap_en=4'b0101 -> tap_valid=0101, taps 1,3 read 0, latency still 7; reset low in WRITE -> ram_we drops immediately, no frame_done.
REQ-037 TAP_MOD_EN build, 70 frames -> tap1 address offset = 0x080+LFO, LFO peaks 63 then descends; tap0 unmodulated.

Source files
------------

// File: rtl/delay_ram_scheduler_pkg.sv
// Shared defaults, FSM state type and power-on tap offset table for the delay-RAM scheduler.
package delay_sched_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 11;
  localparam int NTAPS_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  // Taps beyond the table start at offset 0.
  function automatic logic [15:0] default_offset(input int k);
    case (k)
      0:       return 16'h001;
      1:       return 16'h080;
      2:       return 16'h0C0;
      3:       return 16'h100;
      default: return 16'h000;
    endcase
  endfunction

endpackage

// File: rtl/delay_ram_scheduler_if.sv
// Delay-RAM port bundle: the scheduler drives address/write, the RAM returns read data one cycle later.
interface delay_ram_scheduler_if
  import delay_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_we, ram_addr, ram_wdata, input ram_rdata);
  modport slave  (input ram_we, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/delay_ram_scheduler_lfo.sv
// tap_lfo: 6-bit triangle generator (0..63..0) that advances one step per strobe.
// Only instantiated when TAP_MOD_EN is defined.
module tap_lfo (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [5:0] value
);
  logic down;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= 6'd0;
      down  <= 1'b0;
    end else if (step) begin
      if (!down) begin
        if (value == 6'd63) begin
          down  <= 1'b1;
          value <= 6'd62;
        end else begin
          value <= value + 6'd1;
        end
      end else begin
        if (value == 6'd0) begin
          down  <= 1'b0;
          value <= 6'd1;
        end else begin
          value <= value - 6'd1;
        end
      end
    end
  end
endmodule

// File: rtl/delay_ram_scheduler.sv
// Per-sample delay-line sequencer: NTAPS reads, one write, then publishes tap data.
// Optional macro TAP_MOD_EN adds a triangle LFO to the offsets of taps 1..NTAPS-1.
//   state   | meaning
//   IDLE    | waiting for sample_tick
//   READ    | one RAM read per tap slot
//   CAPTURE | last read data lands
//   WRITE   | store latched sample at wptr
//   DONE    | publish taps, advance wptr, pulse frame_done
module delay_ram_scheduler
  import delay_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NTAPS  = NTAPS_DEF,
  localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [DATA_W-1:0]       wr_sample,
  input  logic [NTAPS-1:0]        tap_en,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [ADDR_W-1:0]       cfg_offset,
  delay_ram_scheduler_if.master   ram,
  output logic [NTAPS*DATA_W-1:0] tap_data,
  output logic [NTAPS-1:0]        tap_valid,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  state_t            state, next_state;
  logic [IDX_W-1:0]  slot, rd_idx;
  logic              rd_pend;
  logic [ADDR_W-1:0] wptr, addr_q, tap_off;
  logic [DATA_W-1:0] sample_q;
  logic [NTAPS-1:0]  en_q;
  logic [ADDR_W-1:0] pending [NTAPS];
  logic [ADDR_W-1:0] active  [NTAPS];
  logic [DATA_W-1:0] taps_q  [NTAPS];

`ifdef TAP_MOD_EN
  logic [5:0] lfo_val;

  tap_lfo u_lfo (
    .clk   (clk),
    .reset (reset),
    .step  (state == S_DONE),
    .value (lfo_val)
  );
`endif

  always_comb begin
    tap_off = active[slot];
`ifdef TAP_MOD_EN
    if (slot != '0) tap_off = tap_off + ADDR_W'(lfo_val);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // ram_addr is combinational from state but falls back to its last value outside READ/WRITE.
  always_comb begin
    next_state    = state;
    ram.ram_we    = 1'b0;
    ram.ram_addr  = addr_q;
    ram.ram_wdata = sample_q;
    frame_done    = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE:    if (sample_tick) next_state = S_READ;
      S_READ: begin
        ram.ram_addr = wptr - tap_off;
        if (slot == IDX_W'(NTAPS - 1)) next_state = S_CAPTURE;
      end
      S_CAPTURE: next_state = S_WRITE;
      S_WRITE: begin
        ram.ram_we   = 1'b1;
        ram.ram_addr = wptr;
        next_state   = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      addr_q    <= '0;
      slot      <= '0;
      rd_idx    <= '0;
      rd_pend   <= 1'b0;
      sample_q  <= '0;
      en_q      <= '0;
      overrun   <= 1'b0;
      tap_data  <= '0;
      tap_valid <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        pending[k] <= ADDR_W'(default_offset(k));
        active[k]  <= ADDR_W'(default_offset(k));
        taps_q[k]  <= '0;
      end
    end else begin
      addr_q  <= ram.ram_addr;
      rd_pend <= (state == S_READ);
      rd_idx  <= slot;
      if (cfg_we) pending[cfg_idx] <= cfg_offset;
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      // Read data for slot k arrives the cycle after its address.
      if (rd_pend) taps_q[rd_idx] <= en_q[rd_idx] ? ram.ram_rdata : '0;
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            sample_q <= wr_sample;
            en_q     <= tap_en;
            slot     <= '0;
            active   <= pending;
          end
        end
        S_READ:  slot <= slot + IDX_W'(1);
        S_WRITE: begin
          tap_valid <= en_q;
          for (int k = 0; k < NTAPS; k++) tap_data[k*DATA_W +: DATA_W] <= taps_q[k];
        end
        S_DONE:  wptr <= wptr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_ram_scheduler.sv
// Self-checking bench for delay_ram_scheduler: directed scenarios plus random frames vs a behavioural delay-line model.
module tb_delay_ram_scheduler;
  import delay_sched_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 11;
  localparam int NT    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] wr_sample = '0;
  logic [NT-1:0] tap_en = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [AW-1:0] cfg_offset = '0;
  logic [NT*DW-1:0] tap_data;
  logic [NT-1:0]    tap_valid;
  logic             frame_done, busy, overrun;

  delay_ram_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  delay_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(NT)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .wr_sample   (wr_sample),
    .tap_en      (tap_en),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_offset  (cfg_offset),
    .ram         (ram_bus),
    .tap_data    (tap_data),
    .tap_valid   (tap_valid),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, one-cycle read latency.
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
    ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
  int ref_wptr, ref_frames;
  int ref_pend [NT];
  int ref_act  [NT];

  int checks = 0;
  int passes = 0;
  int last_rd_addr [NT];
  int last_we_addr;
  logic [NT*DW-1:0] last_exp_data;

  function automatic int def_off(input int k);
    case (k)
      0: return 'h001;
      1: return 'h080;
      2: return 'h0C0;
      default: return 'h100;
    endcase
  endfunction

  function automatic int tri_lfo(input int n);
    int p;
    p = n % 126;
    return (p <= 63) ? p : 126 - p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    ref_wptr   = 0;
    ref_frames = 0;
    for (int k = 0; k < NT; k++) begin
      ref_pend[k] = def_off(k);
      ref_act[k]  = def_off(k);
    end
  endtask

  task automatic do_reset(input bit check_outputs);
    @(negedge clk);
    reset = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    if (check_outputs) begin
      chk("rst_ram_we", ram_bus.ram_we, 0);
      chk("rst_ram_addr", ram_bus.ram_addr, 0);
      chk("rst_ram_wdata", ram_bus.ram_wdata, 0);
      chk("rst_tap_data", tap_data, 0);
      chk("rst_tap_valid", tap_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cfg_idle(input int idx, input int off);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_offset = AW'(off);
    ref_pend[idx] = off;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] s, input logic [NT-1:0] en,
                           input int glitch, input bit cw, input int ci, input int co);
    int exp_addr [NT];
    logic [NT*DW-1:0] exp_data;
    int lat, we_cnt, we_addr, we_data, off;
    @(negedge clk);
    sample_tick = 1'b1; wr_sample = s; tap_en = en;
    cfg_we = cw; cfg_idx = 2'(ci); cfg_offset = AW'(co);
    for (int k = 0; k < NT; k++) ref_act[k] = ref_pend[k];
    if (cw) ref_pend[ci] = co;
    exp_data = '0;
    for (int k = 0; k < NT; k++) begin
      off = ref_act[k];
`ifdef TAP_MOD_EN
      if (k != 0) off = off + tri_lfo(ref_frames);
`endif
      exp_addr[k] = (ref_wptr - off + 2 * DEPTH) % DEPTH;
      if (en[k]) exp_data[k*DW +: DW] = ref_mem[exp_addr[k]];
    end
    lat = 0; we_cnt = 0; we_addr = -1; we_data = -1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      sample_tick = (n == glitch);
      if (n == glitch) wr_sample = ~s;
      cfg_we = 1'b0;
      if (n <= NT) last_rd_addr[n-1] = int'(ram_bus.ram_addr);
      if (ram_bus.ram_we) begin
        we_cnt++;
        we_addr = int'(ram_bus.ram_addr);
        we_data = int'(ram_bus.ram_wdata);
      end
      if (frame_done) lat = n;
    end
    sample_tick = 1'b0;
    chk("latency", lat, NT + 3);
    for (int k = 0; k < NT; k++) chk($sformatf("rd_addr%0d", k), last_rd_addr[k], exp_addr[k]);
    chk("we_count", we_cnt, 1);
    chk("we_addr", we_addr, ref_wptr);
    chk("we_data", we_data, s);
    chk("tap_valid", tap_valid, en);
    chk("tap_data", tap_data, exp_data);
    chk("busy_done", busy, 1);
    last_we_addr  = we_addr;
    last_exp_data = exp_data;
    ref_mem[ref_wptr] = s;
    ref_wptr   = (ref_wptr + 1) % DEPTH;
    ref_frames++;
  endtask

  initial begin
    logic fd;
    logic [DW-1:0] t1;
    model_reset();
    do_reset(1'b1);

    // Default offsets on the very first frame.
    run_frame(11'h155, 4'hF, -1, 1'b0, 0, 0);
`ifndef TAP_MOD_EN
    chk("first_addr0", last_rd_addr[0], 'h1FFF);
    chk("first_addr1", last_rd_addr[1], 'h1F80);
    chk("first_addr2", last_rd_addr[2], 'h1F40);
    chk("first_addr3", last_rd_addr[3], 'h1F00);
`endif
    chk("first_we_addr", last_we_addr, 0);

    // Config write coinciding with a tick takes effect one frame later.
    run_frame(11'($urandom), 4'hF, -1, 1'b1, 2, 'h010);
    chk("cfg_same_frame", last_rd_addr[2], 'h1F41);
    run_frame(11'($urandom), 4'hF, -1, 1'b0, 0, 0);
    chk("cfg_next_frame", last_rd_addr[2], 'h1FF2);

    // Tick while busy is dropped and flagged.
    chk("overrun_clear", overrun, 0);
    run_frame(11'($urandom), 4'hF, 3, 1'b0, 0, 0);
    chk("overrun_set", overrun, 1);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) cfg_idle($urandom_range(0, NT - 1), $urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0)
        run_frame(11'($urandom), 4'($urandom), -1, 1'b1, $urandom_range(0, NT - 1), $urandom_range(0, 40));
      else
        run_frame(11'($urandom), 4'($urandom), -1, 1'b0, 0, 0);
    end
    chk("overrun_sticky", overrun, 1);

    repeat (4) @(negedge clk);
    chk("tap_hold", tap_data, last_exp_data);

    run_frame(11'($urandom), 4'b0101, -1, 1'b0, 0, 0);
    chk("sparse_valid", tap_valid, 4'b0101);
    chk("sparse_tap1", tap_data[DW +: DW], 0);
    chk("sparse_tap3", tap_data[3*DW +: DW], 0);

    // Reset during WRITE: write strobe drops at once, no completion.
    @(negedge clk);
    sample_tick = 1'b1; wr_sample = 11'h7AA; tap_en = 4'hF;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("we_in_write", ram_bus.ram_we, 1);
    reset = 1'b0;
    #1;
    chk("we_after_rst", ram_bus.ram_we, 0);
    chk("busy_after_rst", busy, 0);
    fd = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      fd = fd | frame_done;
    end
    chk("no_done_after_rst", fd, 0);
    reset = 1'b1;
    model_reset();
    run_frame(11'($urandom), 4'hF, -1, 1'b0, 0, 0);
    run_frame(11'($urandom), 4'hF, -1, 1'b0, 0, 0);

    // Fill the whole RAM with frame indices and wrap.
    do_reset(1'b0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      run_frame(11'(i), 4'hF, -1, 1'b0, 0, 0);
      if (i == DEPTH) chk("wrap_we_addr", last_we_addr, 0);
    end
`ifndef TAP_MOD_EN
    t1 = 11'((DEPTH + 1) - 128);
    chk("wrap_tap1", tap_data[DW +: DW], t1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
